// File: rtl/mmio_store_fifo.sv
// Store-snooping MMIO output port: queues core stores to DATA_ADDR into a FIFO
// drained over a valid/ready stream, with a readable status word at STATUS_ADDR.
module mmio_store_fifo #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] DATA_ADDR   = 32'h64,
  parameter logic [31:0] STATUS_ADDR = 32'h68
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        StatusHit,
  output logic [31:0] StatusData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned DATA_W = 32;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_clr;

  // Handshake decode; a full FIFO accepts a push only when a pop frees a slot.
  always_comb begin
    w_full     = (r_count == CNT_W'(DEPTH));
    w_empty    = (r_count == '0);
    w_push_req = MemWrite & (DataAdr == DATA_ADDR);
    w_pop      = ~w_empty & out_ready;
    w_push     = w_push_req & (~w_full | w_pop);
    w_drop     = w_push_req & ~w_push;
    w_clr      = MemWrite & (DataAdr == STATUS_ADDR) & WriteData[0];
  end

  // Storage array needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= WriteData;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Outputs derive from state only (plus DataAdr for the status decode).
  always_comb begin
    out_valid  = ~w_empty;
    out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    StatusHit  = (DataAdr == STATUS_ADDR);
    StatusData = {r_overflow, w_full, w_empty, 29'(r_count)};
  end

endmodule
